// File: rtl/rx_pkg.sv
// Shared defaults for the UART receiver sample datapath.
package rx_pkg;

  localparam int unsigned CNT_WIDTH_DEF = 3;
  localparam int unsigned SIZE_DEF      = 8;

  // Counter decode points for the default oversample width.
  localparam int unsigned MID  = 2 ** (CNT_WIDTH_DEF - 1);
  localparam int unsigned WRAP = (2 ** CNT_WIDTH_DEF) - 1;

endpackage

// File: rtl/sipo_shifter.sv
// Serial-in/parallel-out shift register with saturating fill count and parity.
module sipo_shifter
  import rx_pkg::*;
#(
  parameter int unsigned SIZE = SIZE_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            sr_clr,
  input  logic            sr_shift,
  input  logic            sr_in,
  output logic [SIZE-1:0] sr_out,
  output logic            sr_parity,
  output logic            sr_full
);

  localparam int unsigned CW = $clog2(SIZE + 1);

  logic [SIZE-1:0] sr_q,    sr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            full_q,  full_d;

  // New bits enter at the MSB so the first bit received lands in bit 0.
  always_comb begin
    sr_d    = sr_q;
    count_d = count_q;
    if (sr_clr) begin
      sr_d    = '0;
      count_d = '0;
    end else if (sr_shift) begin
      sr_d = {sr_in, sr_q[SIZE-1:1]};
      if (count_q != CW'(SIZE)) begin
        count_d = count_q + CW'(1);
      end
    end
    full_d = (count_d == CW'(SIZE));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q    <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      count_q <= count_d;
      full_q  <= full_d;
    end
  end

  assign sr_out    = sr_q;
  assign sr_parity = ^sr_q;
  assign sr_full   = full_q;

endmodule

// File: rtl/rx_sample_datapath.sv
// UART receiver datapath: oversample counter with mid/wrap decodes plus SIPO shifter.
module rx_sample_datapath
  import rx_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF,
  parameter int unsigned SIZE      = SIZE_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cnt_clr,
  input  logic                 cnt_en,
  output logic [CNT_WIDTH-1:0] cnt_out,
  output logic                 cnt_mid,
  output logic                 cnt_wrap,
  input  logic                 sr_clr,
  input  logic                 sr_shift,
  input  logic                 sr_in,
  output logic [SIZE-1:0]      sr_out,
  output logic                 sr_parity,
  output logic                 sr_full
);

  localparam logic [CNT_WIDTH-1:0] CNT_MID  = CNT_WIDTH'(2 ** (CNT_WIDTH - 1));
  localparam logic [CNT_WIDTH-1:0] CNT_WRAP = '1;

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // Clear beats enable; the increment wraps naturally at the counter width.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (cnt_en) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_out  = cnt_q;
  assign cnt_mid  = (cnt_q == CNT_MID);
  assign cnt_wrap = (cnt_q == CNT_WRAP);

  sipo_shifter #(
    .SIZE (SIZE)
  ) u_sipo (
    .clk       (clk),
    .reset     (reset),
    .sr_clr    (sr_clr),
    .sr_shift  (sr_shift),
    .sr_in     (sr_in),
    .sr_out    (sr_out),
    .sr_parity (sr_parity),
    .sr_full   (sr_full)
  );

endmodule

// File: tb/tb_rx_sample_datapath.sv
// Self-checking bench for rx_sample_datapath against a queue-based reference model.
module tb_rx_sample_datapath;

  logic       clk = 1'b0;
  logic       reset;
  logic       cnt_clr, cnt_en;
  logic [2:0] cnt_out;
  logic       cnt_mid, cnt_wrap;
  logic       sr_clr, sr_shift, sr_in;
  logic [7:0] sr_out;
  logic       sr_parity, sr_full;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: counter value and the bits received since the last clear.
  int m_cnt = 0;
  bit hist[$];

  always #5 clk = ~clk;

  rx_sample_datapath #(
    .CNT_WIDTH (3),
    .SIZE      (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cnt_clr   (cnt_clr),
    .cnt_en    (cnt_en),
    .cnt_out   (cnt_out),
    .cnt_mid   (cnt_mid),
    .cnt_wrap  (cnt_wrap),
    .sr_clr    (sr_clr),
    .sr_shift  (sr_shift),
    .sr_in     (sr_in),
    .sr_out    (sr_out),
    .sr_parity (sr_parity),
    .sr_full   (sr_full)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Last up-to-8 received bits, oldest at the lowest occupied position.
  function automatic logic [7:0] m_sr();
    logic [7:0] v = '0;
    int n = hist.size();
    for (int j = 0; j < n; j++) v[8 - n + j] = hist[j];
    return v;
  endfunction

  task automatic check_all(input string tag);
    logic [7:0] e = m_sr();
    check({tag, " cnt_out"},   32'(cnt_out),   32'(m_cnt));
    check({tag, " cnt_mid"},   32'(cnt_mid),   32'(m_cnt == 4));
    check({tag, " cnt_wrap"},  32'(cnt_wrap),  32'(m_cnt == 7));
    check({tag, " sr_out"},    32'(sr_out),    32'(e));
    check({tag, " sr_parity"}, 32'(sr_parity), 32'($countones(e) % 2));
    check({tag, " sr_full"},   32'(sr_full),   32'(hist.size() == 8));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    if (cnt_clr) m_cnt = 0;
    else if (cnt_en) m_cnt = (m_cnt + 1) % 8;
    if (sr_clr) hist.delete();
    else if (sr_shift) begin
      hist.push_back(bit'(sr_in));
      if (hist.size() > 8) void'(hist.pop_front());
    end
    #1;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    cnt_clr = 0; cnt_en = 0; sr_clr = 0; sr_shift = 0; sr_in = 0;
  endtask

  // Asynchronous reset between edges, released on a falling edge.
  task automatic async_reset(input string tag);
    reset = 1'b1;
    #2;
    m_cnt = 0;
    hist.delete();
    check({tag, " rst cnt_out"}, 32'(cnt_out), 32'd0);
    check({tag, " rst sr_out"},  32'(sr_out),  32'd0);
    check({tag, " rst sr_full"}, 32'(sr_full), 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int exp_seq[10] = '{1, 2, 3, 4, 5, 6, 7, 0, 1, 2};
    bit byte_bits[8] = '{1, 0, 1, 0, 0, 1, 0, 1};

    idle_inputs();
    reset = 1'b1;
    #1;
    check_all("por");
    @(negedge clk);
    reset = 1'b0;

    // Free count through a wrap.
    cnt_en = 1;
    for (int i = 0; i < 10; i++) begin
      step("count");
      check("count_seq", 32'(cnt_out), 32'(exp_seq[i]));
    end

    // Clear beats enable at value 5.
    for (int i = 0; i < 3; i++) step("to5");
    check("at5", 32'(cnt_out), 32'd5);
    cnt_clr = 1;
    step("cnt_clr_prio");
    check("cnt_clr_prio val", 32'(cnt_out), 32'd0);
    idle_inputs();

    // sr_clr beats sr_shift.
    sr_shift = 1; sr_in = 1;
    step("pre_clr");
    step("pre_clr");
    sr_clr = 1;
    step("sr_clr_prio");
    check("sr_clr_prio val", 32'(sr_out), 32'd0);
    idle_inputs();

    // 8'hA5 received LSB first.
    sr_shift = 1;
    for (int i = 0; i < 8; i++) begin
      sr_in = byte_bits[i];
      step("byte");
      if (i == 6) check("not_full_at7", 32'(sr_full), 32'd0);
    end
    check("byte val",    32'(sr_out),    32'h0A5);
    check("byte full",   32'(sr_full),   32'd1);
    check("byte parity", 32'(sr_parity), 32'd0);

    // Ninth shift drops the oldest bit.
    sr_in = 1;
    step("overflow");
    check("overflow val",    32'(sr_out),    32'h0D2);
    check("overflow full",   32'(sr_full),   32'd1);
    check("overflow parity", 32'(sr_parity), 32'd0);
    idle_inputs();

    // Hold with both enables low.
    for (int i = 0; i < 20; i++) step("hold");
    check("hold val", 32'(sr_out), 32'h0D2);

    // Mid-frame async reset with 8'hA5 loaded and the counter running.
    sr_clr = 1;
    step("reload_clr");
    sr_clr = 0; sr_shift = 1; cnt_en = 1;
    for (int i = 0; i < 8; i++) begin
      sr_in = byte_bits[i];
      step("reload");
    end
    check("reload val", 32'(sr_out), 32'h0A5);
    idle_inputs();
    async_reset("midframe");

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      cnt_clr  = ($urandom % 16) == 0;
      cnt_en   = ($urandom % 4) != 0;
      sr_clr   = ($urandom % 24) == 0;
      sr_shift = ($urandom % 2) == 0;
      sr_in    = 1'($urandom);
      step("rand");
      if (($urandom % 150) == 0) begin
        idle_inputs();
        async_reset("rand");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
